fork_table_arbiter: RTL and testbench
=====================================

// Module: fork_table_arbiter
// PURPOSE
//  Responder side of the philosopher fork protocol. Owns the N forks on a
//  ring table and answers philosopher hunger requests with eat grants.
//  Fork i lies between philosopher i and philosopher (i+1)%N.
//  Philosopher i eats holding fork i (left) and fork (i+N-1)%N (right).
//  Round-robin fairness, eat timeout and starvation flags make liveness observable.
// PARAMETERS
//  N            8   number of philosophers = number of forks; N>=3
//  MAX_EAT      15  max consecutive EATING cycles before forced revoke; >=1
//  STARVE_LIMIT 31  WAITING cycles after which starve[i] asserts; >=1
// PORTS
//  clk        in   1  single clock, all state on posedge
//  reset      in   1  synchronous, active-high
//  req        in   N  req[i]=1: philosopher i hungry (level, held until granted)
//  done       in   N  done[i]=1: philosopher i releases its forks (ignored unless eating)
//  grant      out  N  grant[i]=1: philosopher i owns both forks (registered)
//  fork_busy  out  N  fork_busy[f]=1: fork f is held (combinational from slot state)
//  timeout    out  N  1-cycle pulse: grant[i] revoked by MAX_EAT
//  starve     out  N  sticky per slot: waited >= STARVE_LIMIT cycles; clears on grant
// BEHAVIOUR
//  - Reset: all slots IDLE. grant, timeout and starve are 0. rr_ptr=0. All counters 0.
//    Reset mid-eat drops grant on the next edge; no timeout pulse is emitted.
//  - Per-slot FSM with states IDLE, WAITING and EATING:
//    IDLE    --req & alloc--> EATING
//    IDLE    --req & !alloc--> WAITING
//    WAITING --alloc--> EATING
//    WAITING --!req--> IDLE (request withdrawn; wait counter cleared)
//    EATING  --done--> IDLE
//    EATING  --eat_cnt==MAX_EAT-1 & !done--> IDLE, with timeout[i] pulsed for 1 cycle
//    done and timeout in the same cycle: done wins, no pulse.
//  - grant[i] is (state==EATING). fork_busy[f] is grant[f] | grant[(f+1)%N].
//  - Latency: req sampled at edge t with forks free -> grant=1 after edge t (1 cycle).
//  - Allocation is a combinational scan over k=(rr_ptr+j)%N, j=0..N-1.
//    Slot k is allocated if all of the following hold:
//      * req[k]=1 and slot k is IDLE or WAITING
//      * fork k and fork (k+N-1)%N are not busy in the current registered state
//      * neither fork is claimed by an earlier k in the same scan
//  - Forks released by done or timeout at edge t become allocatable from edge t+1.
//    There is no same-cycle hand-over.
//  - rr_ptr: when any slot is allocated, rr_ptr <= (last allocated k + 1) % N.
//    Otherwise it is unchanged. Width $clog2(N); wrap handled explicitly (N need not be 2^k).
//  - eat_cnt, width $clog2(MAX_EAT+1): cleared on entry to EATING, increments while EATING.
//    wait_cnt, width $clog2(STARVE_LIMIT+1): increments while WAITING, saturates at
//    STARVE_LIMIT; cleared on leaving WAITING.
//  - starve[i] sets when wait_cnt reaches STARVE_LIMIT. It clears when the slot enters
//    EATING, or enters IDLE on withdraw.
//  - Safety invariant: grant[i] & grant[(i+1)%N] is never 1.
// STRUCTURE
//  - Shared package:
//    * typedef enum {IDLE,WAITING,EATING} SlotState
//    * the ring-index helpers left_fork(i)=i and right_fork(i)=(i+N-1)%N
//  - Sub-module fork_slot (one per philosopher): owns the slot FSM, eat_cnt, wait_cnt
//    and starve. Inputs: req, done, alloc. Outputs: grant, timeout, starve.
//  - The top holds rr_ptr, the allocation scan and the fork_busy map.
// TESTING
//  1. N=8; req=8'h01 only -> grant=8'h01 one cycle later; fork_busy=8'h81.
//  2. req=8'h03, rr_ptr=0 -> grant=8'h01. Pulse done[0] -> grant=8'h00 next cycle,
//     then grant=8'h02 the cycle after.
//  3. req=8'hFF from reset -> grant=8'h55, rr_ptr=7. Then done=8'h55 -> next grants
//     are 8'hAA (scan starts at 7).
//  4. MAX_EAT=4, req[3] held, done never -> grant[3] high exactly 4 cycles, timeout[3]
//     pulses 1 cycle, grant[3] re-asserts one cycle later.
//  5. STARVE_LIMIT=6, grant[1] held, req[2]=1 -> starve[2] rises after 6 waiting cycles.
//     done[1] -> starve[2] clears with grant[2].
//  6. reset asserted while grant=8'h55 -> all outputs 0 next edge. Random req/done run of
//     10k cycles -> no adjacent grants and no grant without req.

Source files
------------

// File: rtl/fork_table_arbiter_pkg.sv
// Shared types and ring-index helpers for the fork table arbiter.
// A philosopher i eats with fork i on its left and fork i-1 (mod N) on its right.
package fork_table_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAITING = 2'd1,
    EATING  = 2'd2
  } slot_state_t;

  localparam int N_DEFAULT            = 8;
  localparam int MAX_EAT_DEFAULT      = 15;
  localparam int STARVE_LIMIT_DEFAULT = 31;

  function automatic int left_fork(input int i);
    return i;
  endfunction

  function automatic int right_fork(input int i, input int n);
    return (i == 0) ? (n - 1) : (i - 1);
  endfunction

endpackage

// File: rtl/fork_table_arbiter_slot.sv
// One philosopher slot: IDLE/WAITING/EATING state, eat and wait counters,
// the forced-revoke pulse and the sticky starvation flag.
module fork_slot
  import fork_table_arbiter_pkg::*;
#(
  parameter int MAX_EAT      = MAX_EAT_DEFAULT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic done,
  input  logic alloc,
  output logic grant,
  output logic timeout,
  output logic starve
);

  localparam int EAT_W  = $clog2(MAX_EAT + 1);
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  slot_state_t       state_r, state_s;
  logic [EAT_W-1:0]  eat_cnt_r, eat_cnt_s;
  logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_s;
  logic              grant_r, timeout_r, timeout_s, starve_r, starve_s;

  // Next-state and revoke-pulse decode; done beats the eat limit.
  always_comb begin
    state_s   = state_r;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req) begin
          state_s = alloc ? EATING : WAITING;
        end else begin
          state_s = IDLE;
        end
      end
      WAITING: begin
        if (alloc) begin
          state_s = EATING;
        end else if (!req) begin
          state_s = IDLE;
        end else begin
          state_s = WAITING;
        end
      end
      EATING: begin
        if (done) begin
          state_s = IDLE;
        end else if (eat_cnt_r == EAT_W'(MAX_EAT - 1)) begin
          state_s   = IDLE;
          timeout_s = 1'b1;
        end else begin
          state_s = EATING;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Counter and starvation-flag updates derived from the state transition.
  always_comb begin
    eat_cnt_s  = '0;
    wait_cnt_s = '0;
    starve_s   = 1'b0;
    if (state_r == EATING && state_s == EATING) begin
      eat_cnt_s = eat_cnt_r + EAT_W'(1);
    end else begin
      eat_cnt_s = '0;
    end
    if (state_r == WAITING && state_s == WAITING) begin
      wait_cnt_s = (wait_cnt_r == WAIT_W'(STARVE_LIMIT)) ? wait_cnt_r : wait_cnt_r + WAIT_W'(1);
    end else begin
      wait_cnt_s = '0;
    end
    if (state_s != WAITING) begin
      starve_s = 1'b0;
    end else if (wait_cnt_s == WAIT_W'(STARVE_LIMIT)) begin
      starve_s = 1'b1;
    end else begin
      starve_s = starve_r;
    end
  end

  // Slot state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      eat_cnt_r  <= '0;
      wait_cnt_r <= '0;
      grant_r    <= 1'b0;
      timeout_r  <= 1'b0;
      starve_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      eat_cnt_r  <= eat_cnt_s;
      wait_cnt_r <= wait_cnt_s;
      grant_r    <= (state_s == EATING);
      timeout_r  <= timeout_s;
      starve_r   <= starve_s;
    end
  end

  assign grant   = grant_r;
  assign timeout = timeout_r;
  assign starve  = starve_r;

endmodule

// File: rtl/fork_table_arbiter.sv
// Ring-table fork arbiter: round-robin allocation scan over hungry philosophers,
// fork occupancy map and the rotating priority pointer.
module fork_table_arbiter
  import fork_table_arbiter_pkg::*;
#(
  parameter int N            = N_DEFAULT,
  parameter int MAX_EAT      = MAX_EAT_DEFAULT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic [N-1:0] done,
  output logic [N-1:0] grant,
  output logic [N-1:0] fork_busy,
  output logic [N-1:0] timeout,
  output logic [N-1:0] starve
);

  localparam int PTR_W = $clog2(N);

  logic [PTR_W-1:0] rr_ptr_r, rr_ptr_s;
  logic [N-1:0]     alloc_s, claim_s, busy_s;

  // Fork f is held by philosopher f (left) or philosopher f+1 (right).
  always_comb begin
    busy_s = '0;
    for (int f = 0; f < N; f++) begin
      busy_s[f] = grant[f] | grant[(f + 1) % N];
    end
  end

  // Allocation scan starting at rr_ptr; only registered occupancy is consulted,
  // so forks freed this edge are not handed over until the next one.
  always_comb begin
    int   k;
    int   lf;
    int   rf;
    logic hit;
    k        = 0;
    lf       = 0;
    rf       = 0;
    hit      = 1'b0;
    alloc_s  = '0;
    claim_s  = '0;
    rr_ptr_s = rr_ptr_r;
    for (int j = 0; j < N; j++) begin
      k   = int'(rr_ptr_r) + j;
      k   = (k >= N) ? (k - N) : k;
      lf  = left_fork(k);
      rf  = right_fork(k, N);
      hit = req[PTR_W'(k)] & ~grant[PTR_W'(k)]
          & ~busy_s[PTR_W'(lf)] & ~busy_s[PTR_W'(rf)]
          & ~claim_s[PTR_W'(lf)] & ~claim_s[PTR_W'(rf)];
      alloc_s[PTR_W'(k)]  = alloc_s[PTR_W'(k)] | hit;
      claim_s[PTR_W'(lf)] = claim_s[PTR_W'(lf)] | hit;
      claim_s[PTR_W'(rf)] = claim_s[PTR_W'(rf)] | hit;
      if (hit) begin
        rr_ptr_s = (k == N - 1) ? '0 : PTR_W'(k + 1);
      end else begin
        rr_ptr_s = rr_ptr_s;
      end
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r <= '0;
    end else begin
      rr_ptr_r <= rr_ptr_s;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_slot
    fork_slot #(
      .MAX_EAT      (MAX_EAT),
      .STARVE_LIMIT (STARVE_LIMIT)
    ) u_slot (
      .clk     (clk),
      .reset   (reset),
      .req     (req[g]),
      .done    (done[g]),
      .alloc   (alloc_s[g]),
      .grant   (grant[g]),
      .timeout (timeout[g]),
      .starve  (starve[g])
    );
  end

  assign fork_busy = busy_s;

endmodule

// File: tb/tb_fork_table_arbiter.sv
// Randomized and directed bench for fork_table_arbiter against a behavioural
// table model (who eats, for how long, who waits, who starves).
module tb_fork_table_arbiter;

  localparam int N  = 8;
  localparam int ME = 4;
  localparam int SL = 6;

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] done;
  logic [N-1:0] grant;
  logic [N-1:0] fork_busy;
  logic [N-1:0] timeout;
  logic [N-1:0] starve;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  fork_table_arbiter #(.N(N), .MAX_EAT(ME), .STARVE_LIMIT(SL)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .fork_busy (fork_busy),
    .timeout   (timeout),
    .starve    (starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]      eat;
    logic [N-1:0]      waitf;
    logic [N-1:0]      to;
    logic [N-1:0]      stv;
    logic [N-1:0][7:0] age;
    logic [N-1:0][7:0] wcnt;
    int                rr;
  } model_t;

  model_t m = '0;

  function automatic logic [N-1:0] forks_held(input logic [N-1:0] eating);
    logic [N-1:0] h;
    for (int f = 0; f < N; f++) h[f] = eating[f] | eating[(f + 1) % N];
    return h;
  endfunction

  // One table step: greedy seating in round-robin order, then each diner ages.
  function automatic model_t next_model(input model_t c, input logic [N-1:0] rq,
                                        input logic [N-1:0] dn, input logic rst);
    model_t       n;
    logic [N-1:0] held, claim, pick;
    int           k, lf, rf, last;
    n    = c;
    n.to = '0;
    if (rst) begin
      n = '0;
      return n;
    end
    held  = forks_held(c.eat);
    claim = '0;
    pick  = '0;
    last  = -1;
    for (int j = 0; j < N; j++) begin
      k  = (c.rr + j) % N;
      lf = k;
      rf = (k + N - 1) % N;
      if (rq[k] && !c.eat[k] && !held[lf] && !held[rf] && !claim[lf] && !claim[rf]) begin
        pick[k]   = 1'b1;
        claim[lf] = 1'b1;
        claim[rf] = 1'b1;
        last      = k;
      end
    end
    if (last >= 0) n.rr = (last + 1) % N;
    for (int i = 0; i < N; i++) begin
      if (c.eat[i]) begin
        if (dn[i]) begin
          n.eat[i] = 1'b0;
        end else if (c.age[i] == 8'(ME - 1)) begin
          n.eat[i] = 1'b0;
          n.to[i]  = 1'b1;
        end else begin
          n.age[i] = c.age[i] + 8'd1;
        end
      end else if (pick[i]) begin
        n.eat[i]   = 1'b1;
        n.age[i]   = 8'd0;
        n.waitf[i] = 1'b0;
        n.wcnt[i]  = 8'd0;
        n.stv[i]   = 1'b0;
      end else if (rq[i]) begin
        if (c.waitf[i]) n.wcnt[i] = (c.wcnt[i] >= 8'(SL)) ? 8'(SL) : c.wcnt[i] + 8'd1;
        else            n.wcnt[i] = 8'd0;
        n.waitf[i] = 1'b1;
        if (n.wcnt[i] == 8'(SL)) n.stv[i] = 1'b1;
      end else begin
        n.waitf[i] = 1'b0;
        n.wcnt[i]  = 8'd0;
        n.stv[i]   = 1'b0;
      end
    end
    return n;
  endfunction

  always @(posedge clk) m <= next_model(m, req, done, reset);

  task automatic cmp(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, plus the adjacency invariant.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("grant", grant, m.eat);
      cmp("fork_busy", fork_busy, forks_held(m.eat));
      cmp("timeout", timeout, m.to);
      cmp("starve", starve, m.stv);
      cmp("adjacent_grant", grant & {grant[0], grant[N-1:1]}, '0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    req   = '0;
    done  = '0;
    reset = 1'b1;
    @(posedge clk);
    chk_en = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    cmp("rst_grant", grant, 8'h00);
    cmp("rst_busy", fork_busy, 8'h00);
    cmp("rst_starve", starve, 8'h00);

    // single hungry philosopher
    req = 8'h01; tick(1);
    cmp("t1_grant", grant, 8'h01);
    cmp("t1_busy", fork_busy, 8'h81);
    req = 8'h00; done = 8'h01; tick(1);
    cmp("t1_release", grant, 8'h00);
    done = 8'h00;

    // neighbours contend, no same-cycle hand-over
    reset = 1'b1; tick(1); reset = 1'b0;
    req = 8'h03; tick(1);
    cmp("t2_first", grant, 8'h01);
    done = 8'h01; req = 8'h02; tick(1);
    cmp("t2_gap", grant, 8'h00);
    done = 8'h00; tick(1);
    cmp("t2_second", grant, 8'h02);
    req = 8'h00; done = 8'h02; tick(1); done = 8'h00;

    // full table, rotation, then reset mid-meal
    reset = 1'b1; tick(1); reset = 1'b0;
    req = 8'hFF; tick(1);
    cmp("t3_even", grant, 8'h55);
    done = 8'h55; tick(1);
    cmp("t3_gap", grant, 8'h00);
    done = 8'h00; tick(1);
    cmp("t3_odd", grant, 8'hAA);
    done = 8'hAA; tick(1); done = 8'h00; tick(1);
    cmp("t3_even_again", grant, 8'h55);
    reset = 1'b1; tick(1);
    cmp("t6_rst_grant", grant, 8'h00);
    cmp("t6_rst_busy", fork_busy, 8'h00);
    cmp("t6_rst_timeout", timeout, 8'h00);
    reset = 1'b0; req = 8'h00; tick(1);

    // eat limit forces a revoke
    req = 8'h08; tick(1);
    for (int c = 0; c < ME; c++) begin
      cmp("t4_eating", grant, 8'h08);
      cmp("t4_no_to", timeout, 8'h00);
      tick(1);
    end
    cmp("t4_revoked", grant, 8'h00);
    cmp("t4_pulse", timeout, 8'h08);
    tick(1);
    cmp("t4_regrant", grant, 8'h08);
    cmp("t4_pulse_end", timeout, 8'h00);
    req = 8'h00; done = 8'h08; tick(1); done = 8'h00; tick(1);

    // philosopher 2 starves between 1 and 3
    reset = 1'b1; tick(1); reset = 1'b0;
    req = 8'h0E; tick(1);
    cmp("t5_grant", grant, 8'h0A);
    tick(5);
    cmp("t5_not_yet", starve, 8'h00);
    tick(1);
    cmp("t5_starve", starve, 8'h04);
    done = 8'h0A; req = 8'h04; tick(1);
    cmp("t5_gap", grant, 8'h00);
    cmp("t5_still", starve, 8'h04);
    done = 8'h00; tick(1);
    cmp("t5_fed", grant, 8'h04);
    cmp("t5_clear", starve, 8'h00);
    req = 8'h00; done = 8'h04; tick(1); done = 8'h00;

    // random table traffic
    reset = 1'b1; tick(1); reset = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (m.eat[i]) begin
          req[i]  = ($urandom_range(0, 7) != 0);
          done[i] = ($urandom_range(0, 3) == 0);
        end else if (m.waitf[i]) begin
          req[i]  = ($urandom_range(0, 15) != 0);
          done[i] = ($urandom_range(0, 7) == 0);
        end else begin
          req[i]  = ($urandom_range(0, 3) == 0);
          done[i] = 1'b0;
        end
      end
      reset = ($urandom_range(0, 999) == 0);
      tick(1);
    end
    reset = 1'b0;
    req   = '0;
    done  = '0;
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
